serial_sub: RTL



---
 rtl/serial_sub.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: a - b as a + ~b + 1, one bit per clock.
// Define SERIAL_SUB_ADD_MODE_EN to add the op input (op = 1 selects a + b).
module serial_sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic              b_bit;
  logic              sum_bit;
  logic              carry_nxt;
  logic              ovf_nxt;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic              op_q, op_d;

  assign b_bit   = op_q ? b_q[0] : ~b_q[0];
  // Operands of like sign (add) or unlike sign (subtract) can overflow.
  assign ovf_nxt = (op_q ? ~(a_msb_q ^ b_msb_q) : (a_msb_q ^ b_msb_q)) & (a_msb_q ^ sum_bit);
`else
  assign b_bit   = ~b_q[0];
  assign ovf_nxt = (a_msb_q ^ b_msb_q) & (a_msb_q ^ sum_bit);
`endif

  assign sum_bit   = a_q[0] ^ b_bit ^ carry_q;
  assign carry_nxt = (a_q[0] & b_bit) | ((a_q[0] ^ b_bit) & carry_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
    op_d    = op_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
          op_d    = op;
          carry_d = ~op;
`else
          carry_d = 1'b1;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        diff_d  = {sum_bit, diff_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          c_out_d = carry_nxt;
          ovf_d   = ovf_nxt;
          zero_d  = ~|diff_d;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
      op_q    <= op_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule
